add11_seq_ctrl: RTL and testbench



---
 rtl/add11_seq_ctrl_if.sv | 44 ++++
 rtl/add11_seq_ctrl.sv | 117 +++++++++++
 tb/tb_add11_seq_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/add11_seq_ctrl_if.sv
// add11_seq_ctrl_if
// Operand/result handshake bundle for the sequential 11-operand adder
// controller.
//   in_valid/in_ready/in_data    : operand stream, producer -> controller
//   out_valid/out_ready/out_sum  : frame result, controller -> consumer
//   out_carry                    : wrap count for the frame (present only
//                                  when ADD11_CARRY_EN is defined)
// Modports: master = producer/consumer side, slave = controller side.
interface add11_seq_ctrl_if #(
  parameter int W     = 5,
  parameter int N_OPS = 11
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;

`ifdef ADD11_CARRY_EN
  localparam int CW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  logic [CW-1:0] out_carry;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );
`endif
endinterface

// File: rtl/add11_seq_ctrl.sv
// add11_seq_ctrl
// Sequencing controller that folds N_OPS operands per frame through one
// shared W-bit adder and presents the modulo-2^W sum on a valid/ready port.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (overrides flush)
//   flush  : synchronous frame abort, discards any partial or pending result
//   bus    : add11_seq_ctrl_if.slave (operand input and result output)
//   busy   : high while a frame is in progress (ACCUM or DONE)
// Optional feature: define ADD11_CARRY_EN to add bus.out_carry, the number
// of modular wraps in the frame.
module add11_seq_ctrl #(
  parameter int N_OPS = 11,
  parameter int W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  add11_seq_ctrl_if.slave  bus,
  output logic             busy
);

  localparam int CNTW = $clog2(N_OPS + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(N_OPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [W-1:0]    acc, acc_next;
  logic [CNTW-1:0] cnt, cnt_next;
  logic [W:0]      sum_ext;
  logic            accept;
  logic            handshake;

`ifdef ADD11_CARRY_EN
  localparam int CW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  logic [CW-1:0]   carry, carry_next;
`endif

  // Handshake qualifiers; in_ready depends only on state so there is no
  // combinational path from in_valid or out_ready.
  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = acc;
  assign busy          = (state != IDLE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign handshake     = bus.out_valid && bus.out_ready;

  // One extra bit keeps the carry-out of the shared adder.
  assign sum_ext = {1'b0, acc} + {1'b0, bus.in_data};

`ifdef ADD11_CARRY_EN
  assign bus.out_carry = carry;
`endif

  // Next-state logic. The frame ends on the accept that brings the count to
  // N_OPS; flush overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCUM;
      ACCUM:   if (accept && (cnt == LAST_CNT)) state_next = DONE;
      DONE:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Datapath next values. Returning to IDLE (flush or result handshake)
  // clears everything; an operand arriving with flush is dropped.
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
`ifdef ADD11_CARRY_EN
    carry_next = carry;
`endif
    if (flush || handshake) begin
      acc_next = '0;
      cnt_next = '0;
`ifdef ADD11_CARRY_EN
      carry_next = '0;
`endif
    end else if (accept) begin
      acc_next = sum_ext[W-1:0];
      cnt_next = cnt + 1'b1;
`ifdef ADD11_CARRY_EN
      carry_next = carry + CW'(sum_ext[W]);
`endif
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
`ifdef ADD11_CARRY_EN
      carry <= '0;
`endif
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
`ifdef ADD11_CARRY_EN
      carry <= carry_next;
`endif
    end
  end

endmodule

// File: tb/tb_add11_seq_ctrl.sv
// tb_add11_seq_ctrl
// Self-checking bench for add11_seq_ctrl: directed frames from the test
// plan followed by randomized traffic, checked every cycle against a
// frame-level model (operand count, true integer sum, pending-result flag).
// Define ADD11_CARRY_EN to also check out_carry.
module tb_add11_seq_ctrl;

  localparam int N_OPS = 11;
  localparam int W     = 5;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;

  int assertCount = 0;
  int failCount   = 0;

  // Frame-level reference model.
  int mCount   = 0;
  int mTotal   = 0;
  bit mPending = 0;
  bit started  = 0;

  add11_seq_ctrl_if #(.W(W), .N_OPS(N_OPS)) bus ();

  add11_seq_ctrl #(.N_OPS(N_OPS), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .busy  (busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic ordy,
                               input logic fl, input logic rn);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    rst_n         = rn;
    @(posedge clk);
    #1;
  endtask

  // Model update from the inputs present at each rising edge: reset beats
  // flush, flush beats everything, a pending result blocks new operands.
  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n || flush) begin
      mCount = 0; mTotal = 0; mPending = 1'b0;
    end else if (mPending) begin
      if (bus.out_ready) begin
        mCount = 0; mTotal = 0; mPending = 1'b0;
      end
    end else if (bus.in_valid) begin
      mTotal += int'(bus.in_data);
      mCount++;
      if (mCount == N_OPS) mPending = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("in_ready",  int'(bus.in_ready),  int'(!mPending));
      checkOutput("out_valid", int'(bus.out_valid), int'(mPending));
      checkOutput("busy",      int'(busy),          int'(mCount != 0));
      checkOutput("out_sum",   int'(bus.out_sum),   mTotal % (1 << W));
`ifdef ADD11_CARRY_EN
      checkOutput("out_carry", int'(bus.out_carry), mTotal >> W);
`endif
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    rst_n         = 1'b0;

    // Reset state.
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_in_ready",  int'(bus.in_ready),  1);
    checkOutput("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_out_sum",   int'(bus.out_sum),   0);
    checkOutput("rst_busy",      int'(busy),          0);

    // Basic frame 1..11: 66 mod 32 = 2, two wraps.
    for (int i = 1; i <= N_OPS; i++) applyStimulus(1'b1, W'(i), 1'b1, 1'b0, 1'b1);
    checkOutput("basic_out_valid", int'(bus.out_valid), 1);
    checkOutput("basic_out_sum",   int'(bus.out_sum),   2);
`ifdef ADD11_CARRY_EN
    checkOutput("basic_out_carry", int'(bus.out_carry), 2);
`endif
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("basic_out_valid_drop", int'(bus.out_valid), 0);
    checkOutput("basic_idle_busy",      int'(busy),          0);

    // Saturating operands: 341 mod 32 = 21, ten wraps.
    for (int i = 0; i < N_OPS; i++) applyStimulus(1'b1, 5'd31, 1'b1, 1'b0, 1'b1);
    checkOutput("sat_out_sum", int'(bus.out_sum), 21);
`ifdef ADD11_CARRY_EN
    checkOutput("sat_out_carry", int'(bus.out_carry), 10);
`endif
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure with in_valid held high throughout.
    for (int i = 0; i < N_OPS; i++) applyStimulus(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_in_ready_low", int'(bus.in_ready), 0);
      checkOutput("bp_out_valid",    int'(bus.out_valid), 1);
      applyStimulus(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, W'($urandom), 1'b1, 1'b0, 1'b1);
    checkOutput("bp_after_hs_in_ready", int'(bus.in_ready), 1);
    checkOutput("bp_after_hs_busy",     int'(busy),         0);
    applyStimulus(1'b1, W'($urandom), 1'b1, 1'b0, 1'b1);
    checkOutput("bp_next_frame_busy", int'(busy), 1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);

    // Bubbles: eleven 3s with gaps carrying junk data; 33 mod 32 = 1.
    for (int i = 0; i < N_OPS; i++) begin
      applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
      if (i != N_OPS - 1) applyStimulus(1'b0, W'($urandom), 1'b1, 1'b0, 1'b1);
    end
    checkOutput("bubble_out_valid", int'(bus.out_valid), 1);
    checkOutput("bubble_out_sum",   int'(bus.out_sum),   1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);

    // Flush mid-frame with a colliding operand, then a frame of 1s.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_busy",     int'(busy),        0);
    checkOutput("flush_out_sum",  int'(bus.out_sum), 0);
    checkOutput("flush_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < N_OPS; i++) applyStimulus(1'b1, 5'd1, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_next_sum", int'(bus.out_sum), 11);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);

    // Reset while a result is pending.
    for (int i = 0; i < N_OPS; i++) applyStimulus(1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    checkOutput("rstdone_pre_valid", int'(bus.out_valid), 1);
    applyStimulus(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
    checkOutput("rstdone_out_valid", int'(bus.out_valid), 0);
    checkOutput("rstdone_out_sum",   int'(bus.out_sum),   0);
    checkOutput("rstdone_in_ready",  int'(bus.in_ready),  1);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 199) != 0);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
